// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode
//   seven-segment display. The controller shows one digit at a time and
//   blanks all anodes at the start of each slot to prevent ghosting. A
//   frame snapshot of the digit values and the blank mask keeps each
//   4-digit frame free of tearing.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   BLANK_CYCLES all-anodes-off cycles at the start of each slot (< REFRESH_DIV)
//   CNT_W        slot counter width (2**CNT_W >= REFRESH_DIV)
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   enable      scan enable; low forces the display dark
//   dispA..D    digit values for an[3]..an[0]
//   blank_mask  bit i high blanks the digit on an[i]
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   an          digit anodes, active-low, one-cold
//   frame_done  one-cycle pulse after the last slot of each frame
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] dispA,
  input  logic [3:0] dispB,
  input  logic [3:0] dispC,
  input  logic [3:0] dispD,
  input  logic [3:0] blank_mask,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // With no blanking time a slot begins directly in SHOW.
  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  logic             take_snap;
  logic             fd_nx;
  logic [6:0]       seg_nx;
  logic [3:0]       an_nx;

  // Snapshot storage, indexed by scan position (0 = dispA / an[3]).
  logic [3:0]       snap_digit [4];
  logic [3:0]       snap_mask;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, counter control and output decode.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    take_snap = 1'b0;
    fd_nx     = 1'b0;
    an_nx     = '1;
    seg_nx    = '1;

    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx  = SLOT_START;
          cnt_nx    = '0;
          idx_nx    = '0;
          take_snap = 1'b1;
        end
        BLANK: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == BLANK_LAST) begin
            state_nx = SHOW;
          end
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            cnt_nx   = '0;
            idx_nx   = idx + 2'd1;
            state_nx = SLOT_START;
            if (idx == 2'd3) begin
              take_snap = 1'b1;
              fd_nx     = 1'b1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase

      // Outputs follow the current state one cycle later; gating on enable
      // makes the display go dark on the very next cycle after enable drops.
      if (state == SHOW && !snap_mask[2'd3 - idx]) begin
        an_nx  = ~(4'b1000 >> idx);
        seg_nx = hex7(snap_digit[idx]);
      end
    end
  end

  // Slot counter, digit index, snapshot and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      snap_mask  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        snap_digit[i] <= '0;
      end
      an         <= '1;
      seg        <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      an         <= an_nx;
      seg        <= seg_nx;
      frame_done <= fd_nx;
      if (take_snap) begin
        snap_digit[0] <= dispA;
        snap_digit[1] <= dispB;
        snap_digit[2] <= dispC;
        snap_digit[3] <= dispD;
        snap_mask     <= blank_mask;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Self-checking bench for display_scan_ctrl with REFRESH_DIV=8 and
//   BLANK_CYCLES=2. A reference model tracks time since the scan was
//   enabled and derives the expected digit, anode and frame pulse from
//   slot arithmetic and per-frame snapshots.
module tb_display_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * RD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] dispA = 4'h0;
  logic [3:0] dispB = 4'h0;
  logic [3:0] dispC = 4'h0;
  logic [3:0] dispD = 4'h0;
  logic [3:0] blank_mask = 4'h0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  display_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .dispA     (dispA),
    .dispB     (dispB),
    .dispC     (dispC),
    .dispD     (dispD),
    .blank_mask(blank_mask),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fd_seen = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: k counts clock edges since the enabling edge.
  bit         active = 0;
  int         k = 0;
  logic [3:0] snap [4];
  logic [3:0] smask = 4'h0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_fd = 1'b0;

  task automatic grab();
    snap[0] = dispA;
    snap[1] = dispB;
    snap[2] = dispC;
    snap[3] = dispD;
    smask   = blank_mask;
  endtask

  task automatic model_edge();
    int p, slot, off;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_fd  = 1'b0;
    if (!reset_n || !enable) begin
      active = 0;
    end else if (!active) begin
      active = 1;
      k = 0;
      grab();
    end else begin
      k++;
      p    = k - 1;
      slot = (p / RD) % 4;
      off  = p % RD;
      if (off >= BC && !smask[3 - slot]) begin
        exp_an  = ~(4'b1000 >> slot);
        exp_seg = hex_tbl[snap[slot]];
      end
      if (k % FR == 0) begin
        exp_fd = 1'b1;
        grab();
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    total += 3;
    if (an !== exp_an) begin
      bad++;
      $display("FAIL an t=%0t k=%0d got=%h exp=%h", $time, k, an, exp_an);
    end
    if (seg !== exp_seg) begin
      bad++;
      $display("FAIL seg t=%0t k=%0d got=%h exp=%h", $time, k, seg, exp_seg);
    end
    if (frame_done !== exp_fd) begin
      bad++;
      $display("FAIL frame_done t=%0t k=%0d got=%b exp=%b", $time, k, frame_done, exp_fd);
    end
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Advance until the model sits at position pos within the frame.
  task automatic run_to(input int pos);
    for (int i = 0; i < 2 * FR && !(active && (k % FR) == pos); i++) cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(20);
  endtask

  task automatic test_basic_scan();
    dispA = 4'h2; dispB = 4'h1; dispC = 4'h8; dispD = 4'h4;
    blank_mask = 4'h0;
    enable = 1'b1;
    cyc();
    fd_seen = 0;
    run(2 * FR);
    total++;
    if (fd_seen !== 2) begin
      bad++;
      $display("FAIL frame_count got=%0d exp=2", fd_seen);
    end
  endtask

  task automatic test_snapshot();
    run_to(2 * RD + 2);
    dispA = 4'hF;
    run(FR + RD);
  endtask

  task automatic test_blank_mask();
    dispA = 4'h0;
    blank_mask = 4'b1000;
    run(FR);
    fd_seen = 0;
    run(2 * FR);
    total++;
    if (fd_seen !== 2) begin
      bad++;
      $display("FAIL masked_frame_count got=%0d exp=2", fd_seen);
    end
    blank_mask = 4'h0;
  endtask

  task automatic test_enable_drop();
    run_to(RD + 5);
    enable = 1'b0;
    run(4);
    enable = 1'b1;
    run(FR + 4);
  endtask

  task automatic test_async_reset();
    run_to(2 * RD + 4);
    #2 reset_n = 1'b0;
    #1;
    total += 3;
    if (an !== 4'hF) begin
      bad++;
      $display("FAIL async_an got=%h exp=F", an);
    end
    if (seg !== 7'h7F) begin
      bad++;
      $display("FAIL async_seg got=%h exp=7f", seg);
    end
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL async_fd got=%b exp=0", frame_done);
    end
    @(negedge clk);
    run(3);
    reset_n = 1'b1;
    run(FR + 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        dispA = 4'($urandom); dispB = 4'($urandom);
        dispC = 4'($urandom); dispD = 4'($urandom);
      end
      if ($urandom_range(0, 29) == 0) blank_mask = 4'($urandom);
      enable = ($urandom_range(0, 99) >= 3);
      cyc();
    end
    enable = 1'b1;
    run(FR);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) snap[i] = 4'h0;
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_blank_mask();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
